// File: rtl/l2_write_buffer.sv
// rtl/l2_write_buffer.sv - posted write-back buffer between L2 pmem port and memory
// Optional feature macro: WBUF_READ_FWD_EN (serve read tag hits straight from the buffer).
// Without it, a read that hits a buffered line drains the buffer until no entry matches,
// so memory always holds the newest copy before it is read.
module l2_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic              wb_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int TAG_W = ADDR_W - 4;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    RD_MEM,
    DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [DEPTH];
  logic [LINE_W-1:0]  line_q [DEPTH];
  logic [IDX_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [LINE_W-1:0]  rdata_q;

  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               full;
  logic               empty;
  logic               push;
  logic               coalesce;
  logic               pop;
  logic               fwd_ld;
  logic               pmem_ld;

  // Byte offset within the line never selects anything.
  logic               unused_offset_bits;
  assign unused_offset_bits = ^mem_address[3:0];

  assign req_tag = mem_address[ADDR_W-1:4];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

  // Tag lookup; coalescing guarantees at most one valid entry per tag.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Next-state logic and datapath strobes; writes beat reads, drains only when idle.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    coalesce = 1'b0;
    pop      = 1'b0;
    fwd_ld   = 1'b0;
    pmem_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          if (hit) begin
            coalesce = 1'b1;
            state_d  = RESP;
          end else if (!full) begin
            push    = 1'b1;
            state_d = RESP;
          end else begin
            // Make room; the held write is re-evaluated once the head pops.
            state_d = DRAIN;
          end
        end else if (mem_read) begin
          if (hit) begin
`ifdef WBUF_READ_FWD_EN
            fwd_ld  = 1'b1;
            state_d = RESP;
`else
            state_d = DRAIN;
`endif
          end else begin
            state_d = RD_MEM;
          end
        end else if (!empty) begin
          state_d = DRAIN;
        end
      end
      RD_MEM: begin
        if (pmem_resp) begin
          pmem_ld = 1'b1;
          state_d = RESP;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, FIFO pointers, valid bits and the returned read line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + IDX_W'(1);
        count_q         <= count_q + CNT_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + IDX_W'(1);
        count_q         <= count_q - CNT_W'(1);
      end
      if (fwd_ld) begin
        rdata_q <= line_q[hit_idx];
      end
      if (pmem_ld) begin
        rdata_q <= pmem_rdata;
      end
    end
  end

  // Entry payload; qualified by valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_q]  <= req_tag;
      line_q[tail_q] <= mem_wdata;
    end
    if (coalesce) begin
      line_q[hit_idx] <= mem_wdata;
    end
  end

  // Memory-side outputs follow the state so read and write can never overlap.
  always_comb begin
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state_q == RD_MEM) begin
      pmem_address = {req_tag, 4'b0000};
    end else if (state_q == DRAIN) begin
      pmem_address = {tag_q[head_q], 4'b0000};
      pmem_wdata   = line_q[head_q];
    end
  end

  assign pmem_read  = (state_q == RD_MEM);
  assign pmem_write = (state_q == DRAIN);
  assign mem_resp   = (state_q == RESP);
  assign mem_rdata  = rdata_q;
  assign wb_empty   = empty;

endmodule

// File: tb/tb_l2_write_buffer.sv
// tb/tb_l2_write_buffer.sv - directed bench for l2_write_buffer
module tb_l2_write_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [127:0] pmem_wdata;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic         wb_empty;

  always #5 clk = ~clk;

  l2_write_buffer #(.DEPTH(4), .LINE_W(128), .ADDR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .pmem_wdata   (pmem_wdata),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .wb_empty     (wb_empty)
  );

  int errors = 0;
  int checks = 0;

  bit           mem_auto = 1'b0;
  int           mem_lat  = 0;
  logic [127:0] mem_model [logic [15:0]];
  logic [16:0]  pmem_log [$];
  logic [127:0] wr_data_log [$];
  bit           both_seen = 1'b0;
  logic [127:0] last_rdata;

  localparam logic [127:0] L1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] L2 = 128'hAAAA5555_BBBB6666_CCCC7777_DDDD8888;
  localparam logic [127:0] LX = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
  localparam logic [127:0] LY = 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00;
  localparam logic [127:0] LQ = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [15:0] a);
    return {8{a}};
  endfunction

  function automatic logic [16:0] log_at(input int i);
    if (i < pmem_log.size()) return pmem_log[i];
    return '1;
  endfunction

  function automatic logic [127:0] data_at(input int i);
    if (i < wr_data_log.size()) return wr_data_log[i];
    return '1;
  endfunction

  // Memory responder: answers any pmem request after mem_lat cycles when enabled.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && rst_n && (pmem_read || pmem_write)) begin
        for (int k = 0; k < mem_lat; k++) @(negedge clk);
        if (pmem_write) begin
          mem_model[pmem_address] = pmem_wdata;
          pmem_log.push_back({1'b1, pmem_address});
          wr_data_log.push_back(pmem_wdata);
        end else begin
          pmem_log.push_back({1'b0, pmem_address});
          pmem_rdata = mem_model.exists(pmem_address) ? mem_model[pmem_address] : '0;
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (pmem_read && pmem_write) both_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_req();
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic do_reset();
    mem_auto = 1'b0;
    release_req();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    pmem_log.delete();
    wr_data_log.delete();
  endtask

  task automatic wait_resp(input int budget, output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= budget && !got; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        got        = 1'b1;
        lat        = i;
        last_rdata = mem_rdata;
      end
      tick();
    end
  endtask

  task automatic req(input bit wr, input logic [15:0] a, input logic [127:0] d,
                     output int lat, output bit got);
    mem_write   = wr;
    mem_read    = !wr;
    mem_address = a;
    mem_wdata   = d;
    wait_resp(400, lat, got);
  endtask

  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (wb_empty && !pmem_write && !pmem_read) ok = 1'b1;
      tick();
    end
  endtask

  initial begin
    int lat;
    bit got;
    bit ok;
    bit hold_ok;
    bit all_got;

    rst_n       = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_wb_empty", 128'(wb_empty), 128'd1);
    check("rst_mem_resp", 128'(mem_resp), 128'd0);
    check("rst_pmem_read", 128'(pmem_read), 128'd0);
    check("rst_pmem_write", 128'(pmem_write), 128'd0);
    check("rst_pmem_address", 128'(pmem_address), 128'd0);
    check("rst_pmem_wdata", pmem_wdata, 128'd0);
    check("rst_mem_rdata", mem_rdata, 128'd0);
    tick();

    // T1: single write, then idle drain
    req(1'b1, 16'h1230, L1, lat, got);
    check("t1_got_resp", 128'(got), 128'd1);
    check("t1_latency", 128'(lat), 128'd2);
    release_req();
    @(negedge clk);
    check("t1_no_early_drain", 128'(pmem_write), 128'd0);
    @(negedge clk);
    check("t1_drain_write", 128'(pmem_write), 128'd1);
    check("t1_drain_addr", 128'(pmem_address), 128'h1230);
    check("t1_drain_data", pmem_wdata, L1);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("t1_empty_after", 128'(wb_empty), 128'd1);
    check("t1_write_dropped", 128'(pmem_write), 128'd0);
    tick();

    // T2: fill the buffer, fifth write must wait for the oldest drain
    do_reset();
    all_got = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req(1'b1, 16'(i * 16), line_of(16'(i * 16)), lat, got);
      if (!got) all_got = 1'b0;
      if (i == 1) check("t2_first_latency", 128'(lat), 128'd2);
    end
    check("t2_four_accepted", 128'(all_got), 128'd1);
    mem_write   = 1'b1;
    mem_address = 16'h0050;
    mem_wdata   = line_of(16'h0050);
    hold_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_resp) hold_ok = 1'b0;
      tick();
    end
    check("t2_fifth_held", 128'(hold_ok), 128'd1);
    @(negedge clk);
    check("t2_drain_head_write", 128'(pmem_write), 128'd1);
    check("t2_drain_head_addr", 128'(pmem_address), 128'h0010);
    tick();
    mem_lat  = 0;
    mem_auto = 1'b1;
    wait_resp(50, lat, got);
    check("t2_fifth_accepted", 128'(got), 128'd1);
    release_req();
    wait_empty(ok);
    check("t2_drained", 128'(ok), 128'd1);
    check("t2_drain_count", 128'(pmem_log.size()), 128'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_order_%0d", i), 128'(log_at(i)), 128'({1'b1, 16'((i + 1) * 16)}));
      check($sformatf("t2_data_%0d", i), data_at(i), line_of(16'((i + 1) * 16)));
    end

    // T3: coalescing two writes to the same line
    do_reset();
    mem_lat  = 1;
    mem_auto = 1'b1;
    req(1'b1, 16'h2000, L1, lat, got);
    check("t3_first_resp", 128'(got), 128'd1);
    req(1'b1, 16'h2008, L2, lat, got);
    check("t3_second_resp", 128'(got), 128'd1);
    release_req();
    wait_empty(ok);
    check("t3_drained", 128'(ok), 128'd1);
    check("t3_one_write", 128'(pmem_log.size()), 128'd1);
    check("t3_write_addr", 128'(log_at(0)), 128'({1'b1, 16'h2000}));
    check("t3_write_data", data_at(0), L2);

    // T4: read after write to the same line
    do_reset();
    mem_lat  = 1;
    mem_auto = 1'b1;
    req(1'b1, 16'h3000, LX, lat, got);
    check("t4_write_resp", 128'(got), 128'd1);
    req(1'b0, 16'h3004, '0, lat, got);
    check("t4_read_resp", 128'(got), 128'd1);
    check("t4_read_data", last_rdata, LX);
    release_req();
    wait_empty(ok);
    check("t4_drained", 128'(ok), 128'd1);
    check("t4_first_pmem", 128'(log_at(0)), 128'({1'b1, 16'h3000}));
`ifdef WBUF_READ_FWD_EN
    check("t4_no_pmem_read", 128'(pmem_log.size()), 128'd1);
`else
    check("t4_pmem_count", 128'(pmem_log.size()), 128'd2);
    check("t4_pmem_read", 128'(log_at(1)), 128'({1'b0, 16'h3000}));
`endif

    // T5: read miss with slow memory, queued entry drains afterwards
    do_reset();
    req(1'b1, 16'h6000, LQ, lat, got);
    check("t5_write_resp", 128'(got), 128'd1);
    mem_write   = 1'b0;
    mem_read    = 1'b1;
    mem_address = 16'h4000;
    @(negedge clk);
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!pmem_read || pmem_write || mem_resp || (pmem_address != 16'h4000)) hold_ok = 1'b0;
    end
    check("t5_rd_mem_hold", 128'(hold_ok), 128'd1);
    pmem_rdata = LY;
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b0;
    check("t5_resp_after_pmem", 128'(mem_resp), 128'd1);
    check("t5_rdata", mem_rdata, LY);
    check("t5_no_write_yet", 128'(pmem_write), 128'd0);
    tick();
    release_req();
    @(negedge clk);
    @(negedge clk);
    check("t5_late_drain", 128'(pmem_write), 128'd1);
    check("t5_late_drain_addr", 128'(pmem_address), 128'h6000);
    tick();
    mem_lat  = 0;
    mem_auto = 1'b1;
    wait_empty(ok);
    check("t5_drained", 128'(ok), 128'd1);

    // Table of back-to-back L2 operations with an auto-responding memory
    vecs[0] = '{wr: 1'b1, addr: 16'h0100, data: 128'hA, exp: '0};
    vecs[1] = '{wr: 1'b1, addr: 16'h0108, data: 128'hB, exp: '0};
    vecs[2] = '{wr: 1'b0, addr: 16'h0100, data: '0,     exp: 128'hB};
    vecs[3] = '{wr: 1'b1, addr: 16'h0200, data: 128'hC, exp: '0};
    vecs[4] = '{wr: 1'b0, addr: 16'h0500, data: '0,     exp: 128'hD};
    vecs[5] = '{wr: 1'b0, addr: 16'h0200, data: '0,     exp: 128'hC};
    vecs[6] = '{wr: 1'b1, addr: 16'h0100, data: 128'hE, exp: '0};
    vecs[7] = '{wr: 1'b0, addr: 16'h0104, data: '0,     exp: 128'hE};
    do_reset();
    mem_model[16'h0500] = 128'hD;
    mem_lat  = 1;
    mem_auto = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, got);
      check($sformatf("vec%0d_resp", i), 128'(got), 128'd1);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp);
    end
    release_req();
    wait_empty(ok);
    check("vec_drained", 128'(ok), 128'd1);
    check("vec_mem_0100", mem_model[16'h0100], 128'hE);
    check("vec_mem_0200", mem_model[16'h0200], 128'hC);

    // T6: asynchronous reset during a drain
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 16'(16'h7000 + i * 16), line_of(16'(16'h7000 + i * 16)), lat, got);
    end
    release_req();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (pmem_write) got = 1'b1;
    end
    check("t6_drain_started", 128'(got), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_write_killed", 128'(pmem_write), 128'd0);
    check("t6_empty_now", 128'(wb_empty), 128'd1);
    tick();
    rst_n = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pmem_read || pmem_write || !wb_empty) hold_ok = 1'b0;
    end
    check("t6_quiet_after", 128'(hold_ok), 128'd1);

    check("never_rd_and_wr", 128'(both_seen), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
